ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Board-side output stage that consumes the pipeline's `pc_out` and `register_out` debug values.
- Snapshots one selected 32-bit value and shows 16 bits of it as four hex digits on a common-anode 7-segment display.
- Digits are time-multiplexed, with a programmable blanking gap between digits to suppress ghosting.
- Sits directly downstream of the pipeline top, in the FPGA board wrapper.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit is lit (must be ≥1).
- BLANK_CYC, 1000, clock cycles all anodes are off between digits (0 means no blank phase).
- CNT_W, 17, width of the scan counter (must hold max(SCAN_DIV, BLANK_CYC)−1).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- pc_value  in  32  current PC from the pipeline.
- reg_value  in  32  register-file word selected by `register_switch`.
- sel_source  in  1  0 = PC, 1 = register; sampled only when `update`=1.
- sel_half  in  1  0 = bits [15:0], 1 = bits [31:16]; live, not snapshotted.
- update  in  1  when high at a rising edge, the snapshot loads the selected source.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Clock and reset:
  - Single clock, `clock`.
  - `reset` is asynchronous and active-high.
  - Reset has priority over every other event, including `update` in the same cycle.
- Reset values:
  - snap = 0, state = SHOW, digit = 0, cnt = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
- Snapshot:
  - On a rising edge with `update`=1: snap ← sel_source ? reg_value : pc_value.
  - Holding `update` high continuously tracks the source live.
  - `update` during BLANK or mid-digit is legal; the new value appears at the next registered output update.
- Displayed half:
  - half = sel_half ? snap[31:16] : snap[15:0].
  - Digit i shows half[4i+3:4i].
- Scan FSM, states SHOW and BLANK:
  - SHOW: cnt increments each cycle. When cnt = SCAN_DIV−1: cnt ← 0, and
    - if BLANK_CYC > 0, go to BLANK;
    - else digit ← digit+1 mod 4 and stay in SHOW.
  - BLANK: cnt increments. When cnt = BLANK_CYC−1: cnt ← 0, digit ← digit+1 mod 4, go to SHOW.
  - digit wraps 3 → 0.
- Outputs are registered, one cycle behind state, digit and snap:
  - In SHOW: an = ~(4'b0001 << digit); seg = hex(half nibble); dp = 0 only when digit = 3 and sel_half = 1, else 1.
  - In BLANK: an = 1111, seg = 1111111, dp = 1.
- Hex table (seg, hex, active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30
  - 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03
  - C = 46, d = 21, E = 06, F = 0E
- Timing:
  - Full refresh period = 4·(SCAN_DIV + BLANK_CYC) cycles.
  - The first digit-0 pattern appears on the first rising edge after reset deasserts.
  - At most one anode is low at any time, in every cycle.
- Reset mid-scan: outputs go to their reset values immediately (asynchronously); scanning restarts at digit 0 with cnt = 0.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits among 3..1 of the displayed half are suppressed.
  - A suppressed digit keeps an = 1111 and seg = 1111111 for its SHOW slot; slot timing is unchanged.
  - Digit 0 is always shown.
  - dp on digit 3 is still driven when sel_half = 1, even if that digit is suppressed (anode stays off, so it is not visible).
- Undefined: all four digits are always shown, including zeros.

Decomposition:
- Shared package (ssd_pkg):
  - NUM_DIGITS = 4.
  - State encoding SHOW / BLANK.
  - 16-entry active-low segment constants, SEG_BLANK = 7'h7F, AN_OFF = 4'hF.
- Sub-module hex7seg: combinational 4-bit → 7-bit decoder using the package constants; one instance.

Test Plan (SCAN_DIV=4, BLANK_CYC=2 unless noted):
1. Reset asserted, then released → an=1111, seg=7F, dp=1 during reset; the first post-reset edge gives an=1110, seg=40.
2. pc_value=0x0040_001C, sel_source=0, update pulse, sel_half=0 → digits 0..3 show C, 1, 0, 0 (46, 79, 40, 40), each lit 4 cycles, separated by 2 all-off cycles, refresh period 24 cycles; sel_half=1 → digits show 0, 4, 0, 0 with dp=0 only on an=0111.
3. reg_value=0xDEADBEEF, sel_source=1, update together with reset → snap stays 0; an update one cycle later → low half shows F, E, E, b (0E, 06, 06, 03).
4. BLANK_CYC=0 → digits advance every 4 cycles with no all-off cycles; one-hot-low anode check holds every cycle.
5. Reset asserted mid-BLANK of digit 2 → outputs go off asynchronously; after release, scanning restarts at digit 0.
6. SSD_LEADING_ZERO_BLANK_EN defined, snap=0x0000_0005 → digits 3..1 stay off for their slots; digit 0 shows 12. Undefined → 40, 40, 40 shown on digits 3..1.

Source files
------------

// File: rtl/ssd_pkg.sv
// ============================================================================
//  Module   : ssd_pkg
//  Purpose  : Shared constants and state encoding for the 7-segment scan driver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/ssd_scan_driver_hex7seg.sv
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational 4-bit to active-low 7-segment decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
// ============================================================================
//  Module   : ssd_scan_driver
//  Purpose  : Snapshots PC/register value, scans 16 bits onto a 4-digit
//             common-anode display. Optional: SSD_LEADING_ZERO_BLANK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int CNT_W     = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_value,
    input  logic [31:0] reg_value,
    input  logic        sel_source,
    input  logic        sel_half,
    input  logic        update,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    scan_state_t      state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      snap_q,  snap_d;
    logic [3:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;
    logic             dp_q,    dp_d;

    logic [15:0] half;
    logic [3:0]  nibble;
    logic [6:0]  hex_seg;
    logic        suppress;

    assign half = sel_half ? snap_q[31:16] : snap_q[15:0];

    always_comb begin
        nibble = half[3:0];
        case (digit_q)
            2'd1:    nibble = half[7:4];
            2'd2:    nibble = half[11:8];
            2'd3:    nibble = half[15:12];
            default: nibble = half[3:0];
        endcase
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (hex_seg)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every digit to its left are zero
    assign suppress = ((digit_q == 2'd3) && (half[15:12] == 4'h0)) ||
                      ((digit_q == 2'd2) && (half[15:8]  == 8'h00)) ||
                      ((digit_q == 2'd1) && (half[15:4]  == 12'h000));
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q + CNT_W'(1);
        snap_d  = snap_q;
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;

        if (update) begin
            snap_d = sel_source ? reg_value : pc_value;
        end

        if (state_q == SHOW) begin
            if (cnt_q == SCAN_LAST) begin
                cnt_d = '0;
                if (BLANK_CYC > 0) begin
                    state_d = BLANK;
                end else begin
                    digit_d = digit_q + 2'd1;
                end
            end
            if (!suppress) begin
                an_d  = ~(4'b0001 << digit_q);
                seg_d = hex_seg;
            end
            dp_d = !((digit_q == 2'd3) && sel_half);
        end else begin
            if (cnt_q == BLANK_LAST) begin
                cnt_d   = '0;
                digit_d = digit_q + 2'd1;
                state_d = SHOW;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SHOW;
            digit_q <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
// ============================================================================
//  Module   : tb_ssd_scan_driver
//  Purpose  : Self-checking bench for ssd_scan_driver (blank gap and no-gap
//             instances driven from the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssd_scan_driver;

    localparam int S = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc_value;
    logic [31:0] reg_value;
    logic        sel_source;
    logic        sel_half;
    logic        update;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    ssd_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(2), .CNT_W(3)) u_dut_gap (
        .clock(clk), .reset(rst), .pc_value(pc_value), .reg_value(reg_value),
        .sel_source(sel_source), .sel_half(sel_half), .update(update),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    ssd_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(0), .CNT_W(3)) u_dut_nogap (
        .clock(clk), .reset(rst), .pc_value(pc_value), .reg_value(reg_value),
        .sel_source(sel_source), .sel_half(sel_half), .update(update),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     rg;
        logic            src;
        logic            half;
        logic [3:0][6:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    typedef struct packed {
        logic       chk;
        logic       idx;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t            sb[$];
    vec_t            vecs[7];
    int              checks = 0;
    int              errors = 0;
    int              m_digit[2];
    int              m_pos[2];
    int              blank_of[2] = '{2, 0};
    logic [3:0][6:0] cur_segs;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit suppressed(input int d);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < 4; j++)
            if (cur_segs[j] != 7'h40) return 1'b0;
        return 1'b1;
`else
        return (d < 0);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_digit[k] = 0;
            m_pos[k]   = 0;
        end
        cur_segs = {4{7'h40}};
    endtask

    // Predict the coming edge's outputs, advance the model, then compare.
    task automatic run_cycle(input bit chk);
        exp_t       e;
        logic [3:0] one;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        for (int k = 0; k < 2; k++) begin
            e.chk = chk;
            e.idx = (k == 1);
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            if (m_pos[k] < S) begin
                if (!suppressed(m_digit[k])) begin
                    one   = 4'b0001;
                    one   = one << m_digit[k];
                    e.an  = ~one;
                    e.seg = cur_segs[m_digit[k]];
                end
                e.dp = !((m_digit[k] == 3) && sel_half);
            end
            sb.push_back(e);
            m_pos[k]++;
            if (m_pos[k] == S + blank_of[k]) begin
                m_pos[k]   = 0;
                m_digit[k] = (m_digit[k] + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = e.idx ? an1  : an0;
            s = e.idx ? seg1 : seg0;
            d = e.idx ? dp1  : dp0;
            check(e.idx ? "onehot_nogap" : "onehot_gap", ($countones(~a) <= 1), 1);
            if (e.chk) begin
                check(e.idx ? "an_nogap"  : "an_gap",  a, e.an);
                check(e.idx ? "seg_nogap" : "seg_gap", s, e.seg);
                check(e.idx ? "dp_nogap"  : "dp_gap",  d, e.dp);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an0"},  an0,  4'hF);
        check({tag, "_seg0"}, seg0, 7'h7F);
        check({tag, "_dp0"},  dp0,  1);
        check({tag, "_an1"},  an1,  4'hF);
        check({tag, "_seg1"}, seg1, 7'h7F);
        check({tag, "_dp1"},  dp1,  1);
    endtask

    initial begin
        vecs[0] = '{pc: 32'h0040_001C, rg: 32'h0, src: 1'b0, half: 1'b0,
                    segs: {7'h40, 7'h40, 7'h79, 7'h46}};
        vecs[1] = '{pc: 32'h0040_001C, rg: 32'h0, src: 1'b0, half: 1'b1,
                    segs: {7'h40, 7'h40, 7'h19, 7'h40}};
        vecs[2] = '{pc: 32'h0, rg: 32'hDEAD_BEEF, src: 1'b1, half: 1'b0,
                    segs: {7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[3] = '{pc: 32'h0, rg: 32'hDEAD_BEEF, src: 1'b1, half: 1'b1,
                    segs: {7'h21, 7'h06, 7'h08, 7'h21}};
        vecs[4] = '{pc: 32'h0000_0005, rg: 32'hFFFF_FFFF, src: 1'b0, half: 1'b0,
                    segs: {7'h40, 7'h40, 7'h40, 7'h12}};
        vecs[5] = '{pc: 32'h89AB_6723, rg: 32'h0, src: 1'b0, half: 1'b0,
                    segs: {7'h02, 7'h78, 7'h24, 7'h30}};
        vecs[6] = '{pc: 32'h89AB_6723, rg: 32'h0, src: 1'b0, half: 1'b1,
                    segs: {7'h00, 7'h10, 7'h08, 7'h03}};

        // Update coincident with reset must not load the snapshot.
        rst        = 1'b1;
        pc_value   = 32'h0;
        reg_value  = 32'hDEAD_BEEF;
        sel_source = 1'b1;
        sel_half   = 1'b0;
        update     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst    = 1'b0;
        update = 1'b0;
        model_reset();
        repeat (24) run_cycle(1'b1);

        for (int i = 0; i < 7; i++) begin
            pc_value   = vecs[i].pc;
            reg_value  = vecs[i].rg;
            sel_source = vecs[i].src;
            sel_half   = vecs[i].half;
            update     = 1'b1;
            run_cycle(1'b0);
            update   = 1'b0;
            cur_segs = vecs[i].segs;
            repeat (24) run_cycle(1'b1);
        end

        // Asynchronous reset while digit 1 is lit.
        for (int n = 0; n < 100 && !(m_digit[0] == 1 && m_pos[0] == 2); n++)
            run_cycle(1'b1);
        check("reach_digit1", (m_digit[0] == 1 && m_pos[0] == 2), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_show");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (24) run_cycle(1'b1);

        // Reset during the blank gap after digit 2.
        pc_value = 32'h0000_4321;
        sel_half = 1'b0;
        update   = 1'b1;
        run_cycle(1'b0);
        update   = 1'b0;
        cur_segs = {7'h19, 7'h30, 7'h24, 7'h79};
        for (int n = 0; n < 100 && !(m_digit[0] == 2 && m_pos[0] == S + 1); n++)
            run_cycle(1'b1);
        check("reach_blank2", (m_digit[0] == 2 && m_pos[0] == S + 1), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_blank");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (24) run_cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
